mips16_mem_arbiter: RTL and testbench
=====================================

# mips16_mem_arbiter

Arbiter and sequencer for the single-port unified memory of the MIPS16 CPU. It shares one fixed-latency memory port between the instruction-fetch unit (IF) and the load/store unit (LS). It grants one requester at a time, drives the memory for `MEM_LAT` cycles and returns read data with a one-cycle valid pulse. The block sits between the CPU pipeline front/back ends and the memory model inside `CPU`.

## Interface
- `ADDR_W`, 16, address width in bits.
- `DATA_W`, 16, data width in bits.
- `MEM_LAT`, 1, memory access cycles per transfer; must be ≥ 1.

- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — asynchronous, active-low reset.
- `if_req` input 1 — IF requests a read (level).
- `if_addr` input `ADDR_W` — IF address; sampled on grant.
- `if_gnt` output 1 — one-cycle pulse: IF request accepted.
- `if_rdata` output `DATA_W` — IF read data; held until the next IF completion.
- `if_valid` output 1 — one-cycle pulse: `if_rdata` updated.
- `ls_req` input 1 — LS requests a transfer (level).
- `ls_we` input 1 — 1 = write, 0 = read; sampled on grant.
- `ls_addr` input `ADDR_W` — LS address; sampled on grant.
- `ls_wdata` input `DATA_W` — LS write data; sampled on grant.
- `ls_gnt` output 1 — one-cycle pulse: LS request accepted.
- `ls_rdata` output `DATA_W` — LS read data; updated only on LS read completion.
- `ls_valid` output 1 — one-cycle pulse: LS transfer complete (reads and writes).
- `mem_en` output 1 — memory access active.
- `mem_we` output 1 — memory write strobe.
- `mem_addr` output `ADDR_W` — memory address.
- `mem_wdata` output `DATA_W` — memory write data.
- `mem_rdata` input `DATA_W` — memory read data; valid in the last access cycle.

## Operation
- FSM states are IDLE and ACCESS.
- All outputs are registered.

IDLE:
- At a rising edge with any `req` high, select a winner.
- Register `mem_addr`, `mem_we` and `mem_wdata` from the winner; `mem_we` is 0 for IF.
- Set `mem_en` to 1 and pulse the winner's `gnt` to 1.
- Load the down-counter with `MEM_LAT` and go to ACCESS.

ACCESS:
- Requests are ignored.
- The counter decrements each edge.
- At the edge where the counter equals 1:
  - Capture `mem_rdata` into the winner's `rdata` (reads only).
  - Pulse the winner's `valid`.
  - Clear `mem_en` and `mem_we`.
  - Return to IDLE.

Arbitration (default, fixed priority):
- LS wins over IF when both are high.
- IF can starve under continuous LS requests; this is accepted in the default build.

Request rules:
- A requester deasserts `req` the cycle after seeing `gnt`.
- Keeping `req` high after `gnt` is a new, back-to-back request.
- Request inputs only need to be stable at the granting edge.

Reset (`rst` low, at any time, including mid-access):
- FSM goes to IDLE and the counter clears.
- All outputs go to 0: `gnt`, `valid`, `mem_*`, `rdata`.
- An in-flight transfer is abandoned and produces no `valid`.

## Timing
- Request high at edge k → `gnt` high in cycle k..k+1 and `mem_en` high in cycles k..k+`MEM_LAT`.
- `valid` is high for exactly one cycle, after edge k+`MEM_LAT`.
- `rdata` becomes valid in that same cycle.
- Earliest next grant is at edge k+`MEM_LAT`+1.
- Maximum throughput is one transfer per `MEM_LAT`+1 cycles.
- `gnt` and `valid` are never high in the same cycle.
- At most one requester's `gnt` or `valid` is high at a time.
- `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_en` is high.

## Configuration
- Macro: `MIPS16_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - A `last` register records the most recently granted requester; reset value is IF.
  - On a simultaneous request, the requester not in `last` wins.
  - A lone requester always wins.
- Undefined: fixed priority, LS over IF; the `last` register is not built.

## Test plan
- Reset: `rst`=0 mid-ACCESS with `MEM_LAT`=3 → all outputs 0 immediately, no `valid`; after `rst`=1 an IF request at `if_addr`=0x0004 is granted normally.
- IF read with `MEM_LAT`=1: memory word 0x1234 at 0x0010 → `if_gnt` one cycle, then `if_valid` one cycle later with `if_rdata`=0x1234.
- LS write then read with `MEM_LAT`=2: write 0xBEEF to 0x0020 → `mem_we`=1 for 2 cycles and `ls_valid` pulses; then read 0x0020 → `ls_rdata`=0xBEEF.
- Simultaneous requests, both held high for 4 transfers:
  - Default build: grants LS,LS,LS,LS.
  - With `MIPS16_ARB_RR_EN`: grants LS,IF,LS,IF.
- Back-to-back IF reads, `req` held high, `MEM_LAT`=1 → grants every 2 cycles; `if_valid` count equals `if_gnt` count.
- Request during ACCESS: LS granted with `MEM_LAT`=4, IF raises `req` in cycle 2 → IF is granted only on the edge after `ls_valid`.

Source files
------------

// File: rtl/mips16_mem_arbiter.sv
// mips16_mem_arbiter
//   Shares the single fixed-latency port of the MIPS16 unified memory between
//   the instruction-fetch unit (IF, read only) and the load/store unit (LS).
//   One requester is granted at a time. The memory is driven for MEM_LAT
//   cycles, then read data is returned with a one-cycle valid pulse.
//
//   Parameters: ADDR_W (address width), DATA_W (data width),
//               MEM_LAT (access cycles per transfer, >= 1).
//   Ports:
//     clk, rst (async, active low)
//     if_req/if_addr   -> if_gnt/if_rdata/if_valid
//     ls_req/ls_we/ls_addr/ls_wdata -> ls_gnt/ls_rdata/ls_valid
//     mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory
//
//   Build option: define MIPS16_ARB_RR_EN for round-robin arbitration
//   between IF and LS. Without it, LS has fixed priority over IF.
module mips16_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  // Requester encoding used for the transfer owner (and the round-robin history).
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  logic [0:0]        state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              owner_q,     owner_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_gnt_q,    if_gnt_d;
  logic              ls_gnt_q,    ls_gnt_d;
  logic              if_valid_q,  if_valid_d;
  logic              ls_valid_q,  ls_valid_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q,  ls_rdata_d;
  logic              win_ls_s;

`ifdef MIPS16_ARB_RR_EN
  logic              last_q,      last_d;

  // Round-robin winner: on a tie, the requester not granted last time wins.
  always_comb begin
    win_ls_s = 1'b0;
    if (ls_req && if_req) begin
      win_ls_s = (last_q == OWN_IF);
    end else begin
      win_ls_s = ls_req;
    end
  end
`else
  // Fixed-priority winner: LS always beats IF.
  always_comb begin
    win_ls_s = ls_req;
  end
`endif

  // Next-state logic for the IDLE/ACCESS sequencer and all registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    ls_valid_d  = 1'b0;
`ifdef MIPS16_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (if_req || ls_req) begin
          owner_d  = win_ls_s ? OWN_LS : OWN_IF;
          mem_en_d = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = S_ACCESS;
          if (win_ls_s) begin
            mem_addr_d  = ls_addr;
            mem_we_d    = ls_we;
            mem_wdata_d = ls_wdata;
            ls_gnt_d    = 1'b1;
          end else begin
            mem_addr_d  = if_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = {DATA_W{1'b0}};
            if_gnt_d    = 1'b1;
          end
`ifdef MIPS16_ARB_RR_EN
          last_d = win_ls_s ? OWN_LS : OWN_IF;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        // Requests are ignored here; the transfer completes when the
        // counter reaches 1, so mem_en spans exactly MEM_LAT cycles.
        if (cnt_q == CNT_ONE) begin
          cnt_d    = CNT_ZERO;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = S_IDLE;
          if (owner_q == OWN_LS) begin
            ls_valid_d = 1'b1;
            if (!mem_we_q) begin
              ls_rdata_d = mem_rdata;
            end else begin
              ls_rdata_d = ls_rdata_q;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = CNT_ZERO;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // State and output registers; an asynchronous reset abandons any transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= CNT_ZERO;
      owner_q     <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      ls_valid_q  <= 1'b0;
      if_rdata_q  <= {DATA_W{1'b0}};
      ls_rdata_q  <= {DATA_W{1'b0}};
`ifdef MIPS16_ARB_RR_EN
      last_q      <= OWN_IF;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_valid_q  <= if_valid_d;
      ls_valid_q  <= ls_valid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
`ifdef MIPS16_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_valid  = if_valid_q;
  assign ls_valid  = ls_valid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mips16_mem_arbiter.sv
// Testbench for mips16_mem_arbiter. Four instances share the same request
// inputs and differ only in MEM_LAT (instance g has MEM_LAT = g+1); each
// scenario checks the instance whose latency it targets. Each instance has
// its own small memory model.
module tb_mips16_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;

  wire  [3:0]  if_gnt;
  wire  [3:0]  if_valid;
  wire  [3:0]  ls_gnt;
  wire  [3:0]  ls_valid;
  wire  [3:0]  mem_en;
  wire  [3:0]  mem_we;
  wire  [15:0] if_rdata  [4];
  wire  [15:0] ls_rdata  [4];
  wire  [15:0] mem_addr  [4];
  wire  [15:0] mem_wdata [4];
  wire  [15:0] mem_rdata [4];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [15:0] mem [0:255];

    mips16_mem_arbiter #(
      .ADDR_W (16),
      .DATA_W (16),
      .MEM_LAT(g + 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt[g]),
      .if_rdata (if_rdata[g]),
      .if_valid (if_valid[g]),
      .ls_req   (ls_req),
      .ls_we    (ls_we),
      .ls_addr  (ls_addr),
      .ls_wdata (ls_wdata),
      .ls_gnt   (ls_gnt[g]),
      .ls_rdata (ls_rdata[g]),
      .ls_valid (ls_valid[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g])
    );

    assign mem_rdata[g] = mem_en[g] ? mem[mem_addr[g][7:0]] : 16'h0000;

    always @(posedge clk) begin
      if (pre_en) begin
        mem[pre_addr] <= pre_data;
      end else if (mem_en[g] && mem_we[g]) begin
        mem[mem_addr[g][7:0]] <= mem_wdata[g];
      end
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if ({if_gnt, if_valid, ls_gnt, ls_valid, mem_en, mem_we} !== 24'h000000) begin
      errors++;
      $display("FAIL reset_flags: got %h expected 000000",
               {if_gnt, if_valid, ls_gnt, ls_valid, mem_en, mem_we});
    end
    checks++;
    if (mem_addr[0] !== 16'h0000 || mem_wdata[0] !== 16'h0000 ||
        if_rdata[0] !== 16'h0000 || ls_rdata[0] !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h ls_rdata=%h expected all 0000",
               mem_addr[0], mem_wdata[0], if_rdata[0], ls_rdata[0]);
    end
    step();
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_if_read();
    pre_en = 1'b1; pre_addr = 8'h10; pre_data = 16'h1234;
    step();
    pre_en = 1'b0;
    if_addr = 16'h0010; if_req = 1'b1;
    step();
    checks++;
    if (if_gnt[0] !== 1'b1 || mem_en[0] !== 1'b1 || mem_addr[0] !== 16'h0010 ||
        mem_we[0] !== 1'b0 || if_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL if_read_grant: gnt=%b en=%b addr=%h we=%b valid=%b expected 1 1 0010 0 0",
               if_gnt[0], mem_en[0], mem_addr[0], mem_we[0], if_valid[0]);
    end
    if_req = 1'b0;
    step();
    checks++;
    if (if_gnt[0] !== 1'b0 || if_valid[0] !== 1'b1 || if_rdata[0] !== 16'h1234 ||
        mem_en[0] !== 1'b0) begin
      errors++;
      $display("FAIL if_read_valid: gnt=%b valid=%b rdata=%h en=%b expected 0 1 1234 0",
               if_gnt[0], if_valid[0], if_rdata[0], mem_en[0]);
    end
    step();
    checks++;
    if (if_valid[0] !== 1'b0 || if_rdata[0] !== 16'h1234) begin
      errors++;
      $display("FAIL if_read_pulse: valid=%b rdata=%h expected 0 1234", if_valid[0], if_rdata[0]);
    end
    idle(6);
  endtask

  task automatic test_ls_write_read();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0020; ls_wdata = 16'hBEEF;
    step();
    checks++;
    if (ls_gnt[1] !== 1'b1 || mem_en[1] !== 1'b1 || mem_we[1] !== 1'b1 ||
        mem_addr[1] !== 16'h0020 || mem_wdata[1] !== 16'hBEEF) begin
      errors++;
      $display("FAIL ls_write_grant: gnt=%b en=%b we=%b addr=%h wdata=%h expected 1 1 1 0020 beef",
               ls_gnt[1], mem_en[1], mem_we[1], mem_addr[1], mem_wdata[1]);
    end
    ls_req = 1'b0;
    step();
    checks++;
    if (ls_gnt[1] !== 1'b0 || mem_we[1] !== 1'b1 || ls_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL ls_write_cycle2: gnt=%b we=%b valid=%b expected 0 1 0",
               ls_gnt[1], mem_we[1], ls_valid[1]);
    end
    step();
    checks++;
    if (ls_valid[1] !== 1'b1 || mem_we[1] !== 1'b0 || mem_en[1] !== 1'b0 ||
        ls_rdata[1] !== 16'h0000) begin
      errors++;
      $display("FAIL ls_write_done: valid=%b we=%b en=%b rdata=%h expected 1 0 0 0000",
               ls_valid[1], mem_we[1], mem_en[1], ls_rdata[1]);
    end
    idle(6);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0020; ls_wdata = 16'h0000;
    step();
    checks++;
    if (ls_gnt[1] !== 1'b1 || mem_we[1] !== 1'b0) begin
      errors++;
      $display("FAIL ls_read_grant: gnt=%b we=%b expected 1 0", ls_gnt[1], mem_we[1]);
    end
    ls_req = 1'b0;
    idle(2);
    checks++;
    if (ls_valid[1] !== 1'b1 || ls_rdata[1] !== 16'hBEEF) begin
      errors++;
      $display("FAIL ls_read_data: valid=%b rdata=%h expected 1 beef", ls_valid[1], ls_rdata[1]);
    end
    idle(6);
  endtask

  task automatic test_reset_mid_access();
    if_addr = 16'h0008; if_req = 1'b1;
    step();
    if_req = 1'b0;
    step();
    checks++;
    if (mem_en[2] !== 1'b1 || if_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_busy: en=%b valid=%b expected 1 0", mem_en[2], if_valid[2]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({if_gnt[2], if_valid[2], ls_gnt[2], ls_valid[2], mem_en[2], mem_we[2]} !== 6'b000000 ||
        mem_addr[2] !== 16'h0000 || mem_wdata[2] !== 16'h0000 ||
        if_rdata[2] !== 16'h0000 || ls_rdata[2] !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_clear: flags=%b addr=%h wdata=%h if_rdata=%h ls_rdata=%h expected all 0",
               {if_gnt[2], if_valid[2], ls_gnt[2], ls_valid[2], mem_en[2], mem_we[2]},
               mem_addr[2], mem_wdata[2], if_rdata[2], ls_rdata[2]);
    end
    step();
    step();
    checks++;
    if (if_valid[2] !== 1'b0 || mem_en[2] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_novalid: valid=%b en=%b expected 0 0", if_valid[2], mem_en[2]);
    end
    rst = 1'b1;
    step();
    if_addr = 16'h0004; if_req = 1'b1;
    step();
    checks++;
    if (if_gnt[2] !== 1'b1 || mem_addr[2] !== 16'h0004 || mem_en[2] !== 1'b1) begin
      errors++;
      $display("FAIL rst_after_grant: gnt=%b addr=%h en=%b expected 1 0004 1",
               if_gnt[2], mem_addr[2], mem_en[2]);
    end
    if_req = 1'b0;
    idle(2);
    checks++;
    if (if_valid[2] !== 1'b0 || mem_en[2] !== 1'b1) begin
      errors++;
      $display("FAIL rst_after_early: valid=%b en=%b expected 0 1", if_valid[2], mem_en[2]);
    end
    step();
    checks++;
    if (if_valid[2] !== 1'b1 || mem_en[2] !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_valid: valid=%b en=%b expected 1 0", if_valid[2], mem_en[2]);
    end
    idle(6);
  endtask

  task automatic test_simultaneous();
    logic [3:0] seq;
    logic [3:0] exp_seq;
    int n;
    n = 0;
    seq = 4'b0000;
`ifdef MIPS16_ARB_RR_EN
    exp_seq = 4'b0101;
`else
    exp_seq = 4'b1111;
`endif
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    if_addr = 16'h0010; ls_addr = 16'h0020; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    for (int c = 0; c < 20 && n < 4; c++) begin
      step();
      if (if_gnt[0] === 1'b1 || ls_gnt[0] === 1'b1) begin
        checks++;
        if (if_gnt[0] === 1'b1 && ls_gnt[0] === 1'b1) begin
          errors++;
          $display("FAIL simul_both: if_gnt=%b ls_gnt=%b expected only one", if_gnt[0], ls_gnt[0]);
        end
        seq[n] = ls_gnt[0];
        n++;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL simul_count: grants=%0d expected 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seq[i] !== exp_seq[i]) begin
        errors++;
        $display("FAIL simul_order[%0d]: ls_won=%b expected %b", i, seq[i], exp_seq[i]);
      end
    end
    idle(6);
  endtask

  task automatic test_back_to_back();
    logic [10:0] gnt_map;
    logic [10:0] val_map;
    gnt_map = 11'h000;
    val_map = 11'h000;
    if_addr = 16'h0010; if_req = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      step();
      gnt_map[s] = if_gnt[0];
      val_map[s] = if_valid[0];
      if (s == 8) if_req = 1'b0;
    end
    checks++;
    if (gnt_map !== 11'h0AA) begin
      errors++;
      $display("FAIL b2b_gnt: map=%b expected %b", gnt_map, 11'h0AA);
    end
    checks++;
    if (val_map !== 11'h154) begin
      errors++;
      $display("FAIL b2b_valid: map=%b expected %b", val_map, 11'h154);
    end
    checks++;
    if ($countones(gnt_map) != $countones(val_map)) begin
      errors++;
      $display("FAIL b2b_counts: gnt=%0d valid=%0d expected equal",
               $countones(gnt_map), $countones(val_map));
    end
    idle(6);
  endtask

  task automatic test_req_during_access();
    logic [6:0] ifg_map;
    logic [6:0] lsv_map;
    ifg_map = 7'h00;
    lsv_map = 7'h00;
    ls_we = 1'b0; ls_addr = 16'h0020; ls_req = 1'b1;
    step();
    checks++;
    if (ls_gnt[3] !== 1'b1 || if_gnt[3] !== 1'b0) begin
      errors++;
      $display("FAIL busy_ls_grant: ls_gnt=%b if_gnt=%b expected 1 0", ls_gnt[3], if_gnt[3]);
    end
    ls_req = 1'b0;
    if_addr = 16'h0010; if_req = 1'b1;
    for (int s = 2; s <= 6; s++) begin
      step();
      ifg_map[s] = if_gnt[3];
      lsv_map[s] = ls_valid[3];
      if (s == 6) if_req = 1'b0;
    end
    checks++;
    if (lsv_map !== 7'b0100000) begin
      errors++;
      $display("FAIL busy_ls_valid: map=%b expected 0100000", lsv_map);
    end
    checks++;
    if (ifg_map !== 7'b1000000) begin
      errors++;
      $display("FAIL busy_if_grant: map=%b expected 1000000", ifg_map);
    end
    idle(8);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = 16'h0000;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 16'h0000; ls_wdata = 16'h0000;
    pre_en = 1'b0; pre_addr = 8'h00; pre_data = 16'h0000;
    test_reset();
    test_if_read();
    test_ls_write_read();
    test_reset_mid_access();
    test_simultaneous();
    test_back_to_back();
    test_req_during_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
